// File: rtl/ysyx_25040129_burst_sram.sv
// ysyx_25040129_burst_sram
// AXI-style read-only burst SRAM model: one outstanding read burst, FIXED/INCR
// bursts, programmable start latency, DECERR/SLVERR signalling and a side
// preload port for filling the array.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   s_araddr/arlen/arburst   read request (byte address, beats-1, burst type)
//   s_arvalid/s_arready      request handshake (ready only while idle)
//   s_rdata/rresp/rlast      read beat payload
//   s_rvalid/s_rready        beat handshake
//   ld_en/ld_addr/ld_data    preload write port (word index), usable anytime
//
// Build option: define YSYX_25040129_SRAM_RAND_GAP_EN to insert pseudo-random
// idle gaps (0..3 cycles, from a 4-bit LFSR) between beats of a burst.
module ysyx_25040129_burst_sram #(
  parameter int          MEM_WORD_DIG = 10,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [7:0]              s_arlen,
  input  logic [1:0]              s_arburst,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic                    s_rlast,
  input  logic                    ld_en,
  input  logic [MEM_WORD_DIG-1:0] ld_addr,
  input  logic [31:0]             ld_data
);

  localparam int          DEPTH   = 1 << MEM_WORD_DIG;
  localparam int          LW      = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [32:0] TOP_OFF = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_DATA, S_GAP} state_e;

  logic [31:0] mem [DEPTH];

  state_e                  state_q, state_d;
  logic [MEM_WORD_DIG-1:0] idx_q, idx_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              beat_q, beat_d;
  logic                    fixed_q, fixed_d;
  logic [1:0]              resp_q, resp_d;
  logic [LW-1:0]           lat_q, lat_d;
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
  logic [3:0]              lfsr_q, lfsr_d;
  logic [1:0]              gap_q, gap_d;
`endif

  // Preload port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Offset from BASE_ADDR. Low address bits fall below the word boundary and
  // cannot change the range result since BASE_ADDR and the top are word aligned.
  logic [32:0] ar_off;
  logic        ar_in_range;
  assign ar_off      = {1'b0, s_araddr} - {1'b0, BASE_ADDR};
  assign ar_in_range = !ar_off[32] && (ar_off < TOP_OFF);

  assign s_arready = rst && (state_q == S_IDLE);
  assign s_rvalid  = (state_q == S_DATA);
  assign s_rlast   = s_rvalid && (beat_q == len_q);
  assign s_rresp   = s_rvalid ? resp_q : 2'b00;
  // Read is combinational on the array so a preload to the current word
  // shows up the cycle after the write.
  assign s_rdata   = (s_rvalid && resp_q == 2'b00) ? mem[idx_q] : 32'h0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    beat_d  = beat_q;
    fixed_d = fixed_q;
    resp_d  = resp_q;
    lat_d   = lat_q;
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
    lfsr_d  = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    gap_d   = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s_arvalid) begin
          idx_d   = ar_off[MEM_WORD_DIG+1:2];
          len_d   = s_arlen;
          beat_d  = 8'd0;
          fixed_d = (s_arburst == 2'b00);
          // Decode error wins over unsupported burst type.
          resp_d  = !ar_in_range ? 2'b11 : (s_arburst[1] ? 2'b10 : 2'b00);
          if (LATENCY > 0) begin
            state_d = S_LAT;
            lat_d   = LW'(LATENCY);
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_LAT: begin
        if (lat_q == LW'(1)) begin
          lat_d   = '0;
          state_d = S_DATA;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_DATA: begin
        if (s_rready) begin
          if (s_rlast) begin
            state_d = S_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
            if (!fixed_q) idx_d = idx_q + MEM_WORD_DIG'(1);
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
            if (lfsr_q[1:0] != 2'b00) begin
              state_d = S_GAP;
              gap_d   = lfsr_q[1:0];
            end
`endif
          end
        end
      end
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
      S_GAP: begin
        if (gap_q == 2'd1) begin
          gap_d   = 2'd0;
          state_d = S_DATA;
        end else begin
          gap_d = gap_q - 2'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= 8'd0;
      beat_q  <= 8'd0;
      fixed_q <= 1'b0;
      resp_q  <= 2'b00;
      lat_q   <= '0;
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
      lfsr_q  <= 4'b1001;
      gap_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      fixed_q <= fixed_d;
      resp_q  <= resp_d;
      lat_q   <= lat_d;
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_burst_sram.sv
// Self-checking bench for ysyx_25040129_burst_sram: directed and randomized
// bursts checked against an array/arithmetic reference model.
module tb_ysyx_25040129_burst_sram;
  localparam int          MWD   = 10;
  localparam int          DEPTH = 1 << MWD;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [31:0]    s_araddr = '0;
  logic           s_arvalid = 1'b0;
  logic           s_arready;
  logic [7:0]     s_arlen = '0;
  logic [1:0]     s_arburst = '0;
  logic [31:0]    s_rdata;
  logic [1:0]     s_rresp;
  logic           s_rvalid;
  logic           s_rready = 1'b0;
  logic           s_rlast;
  logic           ld_en = 1'b0;
  logic [MWD-1:0] ld_addr = '0;
  logic [31:0]    ld_data = '0;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_m [DEPTH];

  always #5 clk = ~clk;

  ysyx_25040129_burst_sram #(.MEM_WORD_DIG(MWD), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arlen(s_arlen), .s_arburst(s_arburst),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rlast(s_rlast),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
  // Reference gap source: x^4+x^3+1, seeded 4'b1001, advanced every clock.
  logic [3:0] tb_lfsr;
  always @(posedge clk or negedge rst)
    if (!rst) tb_lfsr <= 4'b1001;
    else      tb_lfsr <= {tb_lfsr[2:0], tb_lfsr[3] ^ tb_lfsr[2]};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = w[MWD-1:0];
    ld_data = d;
    mem_m[w] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issue one burst and check every beat. rnd randomizes rready; stall_beat
  // holds rready low 5 cycles on that beat and rewrites the word mid-stall.
  task automatic burst(input logic [31:0] addr, input int len, input logic [1:0] bt,
                       input bit rnd, input int stall_beat);
    longint a, off;
    bit inr;
    int widx, b, st, gs, guard, gexp;
    logic [1:0] er;
    logic [31:0] expd, nv;
    a    = {32'h0, addr};
    off  = a - longint'({32'h0, BASE});
    inr  = (off >= 0) && (off < 4 * DEPTH);
    widx = inr ? int'(off / 4) : 0;
    er   = !inr ? 2'b11 : (bt[1] ? 2'b10 : 2'b00);
    guard = 0;
    while (!s_arready && guard < 100) begin guard++; @(negedge clk); end
    chk("arready_idle", s_arready, 1);
    s_araddr = addr; s_arlen = 8'(len); s_arburst = bt; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    s_arvalid = 1'b0;
    gs = 0;
    while (!s_rvalid && gs < 50) begin gs++; @(negedge clk); end
    chk("latency", gs, LAT);
    b = 0; st = 0; guard = 0;
    while (b <= len) begin
      if (guard++ > 4000) begin
        checks++; errors++;
        $error("FAIL timeout: beat=%0d expected=%0d beats", b, len + 1);
        break;
      end
      ld_en = 1'b0;
      expd = (er == 2'b00) ? mem_m[widx] : 32'h0;
      chk("rvalid", s_rvalid, 1);
      chk("rdata", s_rdata, expd);
      chk("rresp", s_rresp, er);
      chk("rlast", s_rlast, (b == len));
      if (b == stall_beat && st < 5) begin
        s_rready = 1'b0;
        st++;
        if (st == 2 && er == 2'b00) begin
          nv = $urandom;
          ld_en = 1'b1; ld_addr = widx[MWD-1:0]; ld_data = nv;
          mem_m[widx] = nv;
        end
        @(negedge clk);
      end else begin
        s_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        gexp = 0;
`ifdef YSYX_25040129_SRAM_RAND_GAP_EN
        gexp = int'(tb_lfsr[1:0]);
`endif
        @(negedge clk);
        if (s_rready) begin
          if (b == len) begin
            chk("arready_after_last", s_arready, 1);
            chk("rvalid_after_last", s_rvalid, 0);
          end else begin
            if (bt == 2'b01) widx = (widx + 1) % DEPTH;
            gs = 0;
            while (!s_rvalid && gs < 8) begin gs++; @(negedge clk); end
            chk("gap", gs, gexp);
          end
          b++;
        end
      end
    end
    s_rready = 1'b0;
    ld_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("arready_in_reset", s_arready, 0);
    chk("rvalid_in_reset", s_rvalid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("arready_post_reset", s_arready, 1);
    chk("rvalid_post_reset", s_rvalid, 0);
    chk("rlast_post_reset", s_rlast, 0);
    chk("rdata_post_reset", s_rdata, 0);
    chk("rresp_post_reset", s_rresp, 0);

    for (int w = 0; w < DEPTH; w++) preload(w, $urandom);
    preload(0, 32'h11); preload(1, 32'h22); preload(2, 32'h33); preload(3, 32'h44);
    preload(DEPTH - 1, 32'hAA);

    burst(BASE, 3, 2'b01, 1'b0, -1);                       // 11,22,33,44
    burst(BASE + 8, 2, 2'b00, 1'b0, -1);                   // FIXED: 33 x3
    burst(BASE - 4, 1, 2'b01, 1'b0, -1);                   // DECERR below base
    burst(BASE, 1, 2'b10, 1'b0, -1);                       // SLVERR
    burst(BASE + 4 * (DEPTH - 1), 0, 2'b11, 1'b0, -1);     // SLVERR, single beat
    burst(BASE + 4 * DEPTH, 2, 2'b10, 1'b0, -1);           // DECERR wins
    burst(BASE + 4 * 5 + 3, 1, 2'b01, 1'b0, -1);           // low bits ignored
    burst(BASE + 4 * (DEPTH - 1), 1, 2'b01, 1'b0, -1);     // wrap: AA, 11
    burst(BASE + 32'h40, 4, 2'b01, 1'b0, 2);               // stall + live update

    for (int i = 0; i < 8; i++)
      burst(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3),
            $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1'b1, $urandom_range(0, 4));
    burst(32'h0000_1000, 1, 2'b01, 1'b1, -1);              // far below base

    burst(BASE + 4 * $urandom_range(0, DEPTH - 1), 255, 2'b01, 1'b0, -1);
    burst(BASE + 16, 7, 2'b01, 1'b0, -1);

    // Reset mid-burst
    s_araddr = BASE; s_arlen = 8'd7; s_arburst = 2'b01; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rvalid_mid_burst", s_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("rvalid_async_reset", s_rvalid, 0);
    chk("arready_async_reset", s_arready, 0);
    chk("rlast_async_reset", s_rlast, 0);
    chk("rdata_async_reset", s_rdata, 0);
    @(negedge clk);
    s_rready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arready_after_abort", s_arready, 1);
    chk("rvalid_after_abort", s_rvalid, 0);
    @(negedge clk);
    burst(BASE, 3, 2'b01, 1'b0, -1);                       // memory survives reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_25040129_burst_sram.md
YSYX_25040129_BURST_SRAM -- requirements
Module: ysyx_25040129_burst_sram

Interface
REQ-001 SHALL have parameter MEM_WORD_DIG, default 10, log2 of memory depth in 32-bit words (1024 words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, byte address of word 0.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from AR handshake to first rvalid (0 allowed).
REQ-004 SHALL have port clk, input, 1, sole clock, all state on posedge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_araddr in 32 (byte address), s_arvalid in 1, s_arready out 1.
REQ-007 SHALL have ports s_arlen in 8 (beats-1) and s_arburst in 2 (00 FIXED, 01 INCR, others unsupported).
REQ-008 SHALL have ports s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1, s_rlast out 1.
REQ-009 SHALL have preload ports ld_en in 1, ld_addr in MEM_WORD_DIG (word index), ld_data in 32; write on posedge when ld_en.

Function
REQ-010 SHALL implement states IDLE, LAT, DATA (plus GAP, REQ-030 only); one outstanding burst, no read interleaving.
REQ-011 s_arready SHALL be 1 exactly in IDLE; s_rvalid SHALL be 1 exactly in DATA.
REQ-012 On s_arvalid&&s_arready SHALL latch word address (s_araddr-BASE_ADDR)>>2, arlen, arburst; clear beat counter; go LAT if LATENCY>0 else DATA next cycle.
REQ-013 LAT SHALL last LATENCY cycles via down-counter, then DATA.
REQ-014 In DATA, s_rdata SHALL be mem[latched word index]; s_rdata, s_rresp, s_rlast SHALL stay stable while s_rvalid&&!s_rready.
REQ-015 s_rlast SHALL be 1 in DATA iff beat counter == latched arlen.
REQ-016 On beat handshake with s_rlast SHALL return to IDLE; s_arready rises next cycle (no same-cycle AR acceptance).
REQ-017 On beat handshake without s_rlast: beat+1; INCR word index+1 modulo 2^MEM_WORD_DIG; FIXED unchanged.
REQ-018 s_araddr[1:0] SHALL be ignored (word aligned).
REQ-019 Burst start address outside [BASE_ADDR, BASE_ADDR+4*2^MEM_WORD_DIG) SHALL yield arlen+1 beats with s_rresp=2'b11 (DECERR), s_rdata=0.
REQ-020 s_arburst 2'b10/2'b11 with in-range address SHALL yield arlen+1 beats, s_rresp=2'b10 (SLVERR), s_rdata=0; DECERR takes priority.
REQ-021 Otherwise s_rresp SHALL be 2'b00 (OKAY).
REQ-022 arlen=255 SHALL deliver 256 beats; beat counter 8 bits, no overflow.
REQ-023 ld_en write to word currently addressed in DATA SHALL be visible on s_rdata the cycle after the write; preload during bursts is legal.
REQ-024 s_rready held low SHALL stall indefinitely without state loss.

Reset
REQ-025 rst low SHALL asynchronously force IDLE, counters 0, s_rvalid=0, s_rlast=0, s_rresp=0, s_rdata=0, s_arready=1 once rst high.
REQ-026 Reset mid-burst SHALL abort the burst; no further beats; memory contents not cleared.
REQ-027 s_arready SHALL be 0 while rst low.

Configuration
REQ-028 Macro YSYX_25040129_SRAM_RAND_GAP_EN SHALL select random inter-beat gaps.
REQ-029 Without it: back-to-back beats when s_rready=1 (one beat per cycle).
REQ-030 With it: 4-bit LFSR (x^4+x^3+1, reset 4'b1001, steps every cycle); after each non-last beat handshake enter GAP for LFSR[1:0] cycles (0 = straight to DATA) with s_rvalid=0, then DATA.

Verification
REQ-031 Preload words 0..3 = 11,22,33,44; INCR araddr=BASE, arlen=3, rready=1 -> rvalid 2 cycles after AR, beats 11,22,33,44, rlast on 4th only, rresp 00.
REQ-032 FIXED araddr=BASE+8, arlen=2 -> three beats of 33.
REQ-033 araddr=BASE-4, arlen=1 -> two beats rresp 11, rdata 0; arburst=10 at BASE -> rresp 10.
REQ-034 INCR at last word (index 1023), arlen=1, mem[1023]=AA, mem[0]=11 -> beats AA, 11.
REQ-035 rready low 5 cycles on beat 2 -> rdata/rlast stable; rst low mid-burst -> rvalid 0 immediately, next AR accepted.
REQ-036 With YSYX_25040129_SRAM_RAND_GAP_EN, arlen=7 -> 8 correct beats, gap lengths match LFSR model.
